// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the central pipeline controller: stage indices,
// register address width and the default performance-counter width.
package pipe_ctrl_pkg;

    localparam int STG_F      = 0;
    localparam int STG_D      = 1;
    localparam int STG_A      = 2;
    localparam int REG_ADDR_W = 5;
    localparam int PERF_CNT_W = 32;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    function automatic logic reg_dep(input logic uses,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dst);
        return uses && (src == dst) && (dst != '0);
    endfunction

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Enable-qualified event counter that wraps modulo 2^CNT_W.
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: valid bits, ready chain, load-use bubble and branch flush.
// Define PERF_CNT_EN to build the retire/stall/flush performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int BR_STAGE   = 2,
    parameter int CNT_W      = PERF_CNT_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_STAGES-1:0] stage_busy,
    input  logic                  br_en,
    input  logic [REG_ADDR_W-1:0] d_rs1,
    input  logic [REG_ADDR_W-1:0] d_rs2,
    input  logic                  d_uses_rs1,
    input  logic                  d_uses_rs2,
    input  logic [REG_ADDR_W-1:0] a_rd,
    input  logic                  a_is_load,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic                  redirect,
    output logic [CNT_W-1:0]      cnt_retire,
    output logic [CNT_W-1:0]      cnt_stall,
    output logic [CNT_W-1:0]      cnt_flush
);

    logic [NUM_STAGES-1:0] valid_q;
    logic [NUM_STAGES-1:0] valid_d;
    logic [NUM_STAGES-1:0] rdy;
    logic [NUM_STAGES-1:0] en;
    logic                  hazard;
    logic                  redir;
    logic                  carry;

    // A stage is ready when empty, or when it can hand its instruction downstream.
    always_comb begin
        rdy   = '0;
        carry = 1'b1;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            carry  = !valid_q[i] | (!stage_busy[i] & carry);
            rdy[i] = carry;
        end
    end

    always_comb begin
        hazard = valid_q[STG_D] & valid_q[STG_A] & a_is_load
               & (reg_dep(d_uses_rs1, d_rs1, a_rd) | reg_dep(d_uses_rs2, d_rs2, a_rd));
        redir  = br_en & valid_q[BR_STAGE] & !stage_busy[BR_STAGE] & rdy[BR_STAGE+1];

        en = rdy;
        if (hazard) en[STG_D:STG_F] = 2'b00;
        if (redir) begin
            for (int i = 0; i <= BR_STAGE; i++) en[i] = 1'b1;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (en[STG_F]) valid_d[STG_F] = 1'b1;
        for (int i = 1; i < NUM_STAGES; i++) begin
            if (en[i]) begin
                valid_d[i] = valid_q[i-1] & !stage_busy[i-1]
                           & !((i == STG_A) & hazard)
                           & !(redir & (i <= BR_STAGE));
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    assign stage_en    = en;
    assign stage_valid = valid_q;
    assign redirect    = redir;

`ifdef PERF_CNT_EN
    pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_retire (
        .clock (clock),
        .reset (reset),
        .inc   (valid_q[NUM_STAGES-1] & !stage_busy[NUM_STAGES-1]),
        .count (cnt_retire)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_stall (
        .clock (clock),
        .reset (reset),
        .inc   (valid_q[STG_F] & !en[STG_F]),
        .count (cnt_stall)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_flush (
        .clock (clock),
        .reset (reset),
        .inc   (redir),
        .count (cnt_flush)
    );
`else
    assign cnt_retire = '0;
    assign cnt_stall  = '0;
    assign cnt_flush  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: an instruction-slot model tracks which
// stage holds which instruction, plus directed literal expectations.
module tb_pipe_ctrl;

    localparam int N  = 5;
    localparam int BR = 2;
    localparam int CW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  stage_busy = '0;
    logic          br_en = 1'b0;
    logic [4:0]    d_rs1 = '0;
    logic [4:0]    d_rs2 = '0;
    logic          d_uses_rs1 = 1'b0;
    logic          d_uses_rs2 = 1'b0;
    logic [4:0]    a_rd = '0;
    logic          a_is_load = 1'b0;
    logic [N-1:0]  stage_en;
    logic [N-1:0]  stage_valid;
    logic          redirect;
    logic [CW-1:0] cnt_retire;
    logic [CW-1:0] cnt_stall;
    logic [CW-1:0] cnt_flush;

    int checks   = 0;
    int failures = 0;

    pipe_ctrl #(.NUM_STAGES(N), .BR_STAGE(BR), .CNT_W(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .stage_busy  (stage_busy),
        .br_en       (br_en),
        .d_rs1       (d_rs1),
        .d_rs2       (d_rs2),
        .d_uses_rs1  (d_uses_rs1),
        .d_uses_rs2  (d_uses_rs2),
        .a_rd        (a_rd),
        .a_is_load   (a_is_load),
        .stage_en    (stage_en),
        .stage_valid (stage_valid),
        .redirect    (redirect),
        .cnt_retire  (cnt_retire),
        .cnt_stall   (cnt_stall),
        .cnt_flush   (cnt_flush)
    );

    always #5 clock = ~clock;

    // Model: slot[i] holds an instruction id, 0 meaning bubble.
    int           slot[N];
    int           next_id;
    bit           accepts[N+1];
    bit           leaves[N];
    bit           m_hazard;
    bit           m_redirect;
    logic [N-1:0] m_en;
    logic [N-1:0] m_valid;
    longint       m_retire, m_stall, m_flush;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) slot[i] = 0;
        next_id  = 1;
        m_retire = 0;
        m_stall  = 0;
        m_flush  = 0;
    endtask

    task automatic model_eval();
        accepts[N] = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            leaves[i]  = (slot[i] != 0) && !stage_busy[i] && accepts[i+1];
            accepts[i] = (slot[i] == 0) || leaves[i];
        end
        m_hazard = (slot[1] != 0) && (slot[2] != 0) && a_is_load && (a_rd != 0) &&
                   ((d_uses_rs1 && d_rs1 == a_rd) || (d_uses_rs2 && d_rs2 == a_rd));
        m_redirect = br_en && (slot[BR] != 0) && !stage_busy[BR] && accepts[BR+1];
        for (int i = 0; i < N; i++) begin
            m_en[i]    = accepts[i];
            m_valid[i] = (slot[i] != 0);
        end
        if (m_hazard) m_en[1:0] = 2'b00;
        if (m_redirect) for (int i = 0; i <= BR; i++) m_en[i] = 1'b1;
    endtask

    task automatic model_advance();
        int nxt[N];
        model_eval();
        if (leaves[N-1]) m_retire++;
        if ((slot[0] != 0) && !m_en[0]) m_stall++;
        if (m_redirect) m_flush++;
        for (int i = 0; i < N; i++) begin
            if (!m_en[i])                     nxt[i] = slot[i];
            else if (i == 0)                  nxt[i] = next_id++;
            else if (m_redirect && i <= BR)   nxt[i] = 0;
            else if (i == 2 && m_hazard)      nxt[i] = 0;
            else if (leaves[i-1])             nxt[i] = slot[i-1];
            else                              nxt[i] = 0;
        end
        for (int i = 0; i < N; i++) slot[i] = nxt[i];
    endtask

    task automatic settle();
        #1;
        model_eval();
        check("stage_valid", 64'(stage_valid), 64'(m_valid));
        check("stage_en",    64'(stage_en),    64'(m_en));
        check("redirect",    64'(redirect),    64'(m_redirect));
`ifdef PERF_CNT_EN
        check("cnt_retire", 64'(cnt_retire), 64'(m_retire[CW-1:0]));
        check("cnt_stall",  64'(cnt_stall),  64'(m_stall[CW-1:0]));
        check("cnt_flush",  64'(cnt_flush),  64'(m_flush[CW-1:0]));
`else
        check("cnt_retire_zero", 64'(cnt_retire), 64'd0);
        check("cnt_stall_zero",  64'(cnt_stall),  64'd0);
        check("cnt_flush_zero",  64'(cnt_flush),  64'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_advance();
        @(negedge clock);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic clear_events();
        stage_busy = '0;
        br_en      = 1'b0;
        a_is_load  = 1'b0;
        a_rd       = '0;
        d_rs1      = '0;
        d_rs2      = '0;
        d_uses_rs1 = 1'b0;
        d_uses_rs2 = 1'b0;
    endtask

    task automatic fill();
        clear_events();
        for (int k = 0; k < N; k++) step();
        check("fill_full", 64'(stage_valid), 64'h1f);
    endtask

    initial begin
        model_reset();
        @(negedge clock);
        settle();
        check("reset_valid", 64'(stage_valid), 64'h00);
        check("reset_en",    64'(stage_en),    64'h1f);
        tick();

        reset = 1'b1;
        for (int k = 1; k <= N; k++) begin
            step();
            check($sformatf("fill_%0d", k), 64'(stage_valid), 64'((1 << k) - 1));
        end

        // Load-use on rs1 inserts one bubble into A.
        a_is_load = 1'b1; a_rd = 5'd5; d_rs1 = 5'd5; d_uses_rs1 = 1'b1;
        settle();
        check("hazard_en", 64'(stage_en), 64'h1c);
        tick();
        check("hazard_bubble", 64'(stage_valid), 64'h1b);
        clear_events();
        step();
        check("hazard_after", 64'(stage_valid), 64'h17);
        fill();

        // a_rd = x0 never stalls.
        a_is_load = 1'b1; a_rd = 5'd0; d_rs1 = 5'd0; d_uses_rs1 = 1'b1;
        settle();
        check("x0_no_stall", 64'(stage_en), 64'h1f);
        tick();
        check("x0_valid", 64'(stage_valid), 64'h1f);

        // rs2 dependency stalls; matching rs1 that is not read does not.
        clear_events();
        a_is_load = 1'b1; a_rd = 5'd9; d_rs2 = 5'd9; d_uses_rs2 = 1'b1;
        settle();
        check("rs2_stall", 64'(stage_en), 64'h1c);
        clear_events();
        a_is_load = 1'b1; a_rd = 5'd9; d_rs1 = 5'd9; d_uses_rs1 = 1'b0;
        settle();
        check("rs1_unused", 64'(stage_en), 64'h1f);
        tick();
        clear_events();

        // Taken branch flushes D and A.
        br_en = 1'b1;
        settle();
        check("br_redirect", 64'(redirect), 64'd1);
        tick();
        check("br_flush", 64'(stage_valid), 64'h19);
        settle();
        check("br_ignored", 64'(redirect), 64'd0);
        tick();
        fill();

        // Redirect wins over a simultaneous hazard.
        br_en = 1'b1; a_is_load = 1'b1; a_rd = 5'd3; d_rs1 = 5'd3; d_uses_rs1 = 1'b1;
        settle();
        check("prio_en", 64'(stage_en), 64'h1f);
        tick();
        check("prio_flush", 64'(stage_valid), 64'h19);
`ifdef PERF_CNT_EN
        check("cnt_flush_lit", 64'(cnt_flush), 64'd2);
`endif
        fill();

        // Busy C stalls upstream, drains W, and delays a held branch.
        br_en = 1'b1;
        stage_busy[3] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("busy_en", 64'(stage_en), 64'h10);
            check("busy_no_redirect", 64'(redirect), 64'd0);
            tick();
            check("busy_valid", 64'(stage_valid), 64'h0f);
        end
        stage_busy[3] = 1'b0;
        settle();
        check("late_redirect", 64'(redirect), 64'd1);
        tick();
        check("late_flush", 64'(stage_valid), 64'h19);
        fill();

        // Asynchronous reset between edges.
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("async_valid", 64'(stage_valid), 64'h00);
        check("async_en",    64'(stage_en),    64'h1f);
        @(negedge clock);
        settle();
        reset = 1'b1;
        step();
        check("rerelease", 64'(stage_valid), 64'h01);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
